// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side signals of alu_share_arbiter, bundled with
// master (requesters + ALU) and slave (arbiter) views.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  // request channel, bit i / field i = requester i
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [DATA_WIDTH-1:0]    req0_a;
  logic [DATA_WIDTH-1:0]    req0_b;
  logic [OPCODE_LENGTH-1:0] req0_op;
  logic [DATA_WIDTH-1:0]    req1_a;
  logic [DATA_WIDTH-1:0]    req1_b;
  logic [OPCODE_LENGTH-1:0] req1_op;

  // response channel
  logic [1:0]               resp_valid;
  logic [1:0]               resp_ready;
  logic [DATA_WIDTH-1:0]    resp0_result;
  logic [DATA_WIDTH-1:0]    resp1_result;
  logic [1:0]               resp_err;

  // shared combinational ALU
  logic [DATA_WIDTH-1:0]    alu_src_a;
  logic [DATA_WIDTH-1:0]    alu_src_b;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output resp_ready, alu_result,
    input  req_ready, resp_valid, resp0_result, resp1_result, resp_err,
    input  alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  resp_ready, alu_result,
    output req_ready, resp_valid, resp0_result, resp1_result, resp_err,
    output alu_src_a, alu_src_b, alu_op
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// one-entry response buffer each. Define ALU_SHARE_OPCHECK_EN to reject illegal opcodes.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef logic [DATA_WIDTH-1:0]    data_t;
  typedef logic [OPCODE_LENGTH-1:0] op_t;

`ifdef ALU_SHARE_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  localparam op_t OP_AND = op_t'(4'b0000);
  localparam op_t OP_OR  = op_t'(4'b0001);
  localparam op_t OP_ADD = op_t'(4'b0010);
  localparam op_t OP_SUB = op_t'(4'b0011);
  localparam op_t OP_EQ  = op_t'(4'b1000);
  localparam op_t OP_XOR = op_t'(4'b1001);
  localparam op_t OP_SLT = op_t'(4'b1100);

  function automatic logic op_legal(input op_t op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_EQ, OP_XOR, OP_SLT};
  endfunction

  data_t      req_a   [2];
  data_t      req_b   [2];
  op_t        req_op  [2];

  logic [1:0] slot_free;
  logic [1:0] eligible;
  logic       grant_vld;
  logic       grant_idx;
  logic [1:0] accept;
  logic       op_ok;
  data_t      result_in;

  logic       rr_ptr_q,     rr_ptr_d;
  logic [1:0] resp_valid_q, resp_valid_d;
  logic [1:0] resp_err_q,   resp_err_d;
  data_t      resp_result_q [2];
  data_t      resp_result_d [2];

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    req_a[0]  = bus.req0_a;
    req_b[0]  = bus.req0_b;
    req_op[0] = bus.req0_op;
    req_a[1]  = bus.req1_a;
    req_b[1]  = bus.req1_b;
    req_op[1] = bus.req1_op;

    // A full buffer that drains this cycle can take a new result on the same edge.
    slot_free = ~resp_valid_q | bus.resp_ready;
    eligible  = bus.req_valid & slot_free & {2{rst_n}};

    grant_idx = 1'b0;
    unique case (eligible)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = rr_ptr_q;
      default: grant_idx = 1'b0;
    endcase
    grant_vld = |eligible;
    accept    = grant_vld ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    // Without the opcode check every op is forwarded and resp_err stays 0.
    op_ok     = !OPCHECK || op_legal(req_op[grant_idx]);

    bus.alu_src_a = '0;
    bus.alu_src_b = '0;
    bus.alu_op    = '0;
    if (grant_vld && op_ok) begin
      bus.alu_src_a = req_a[grant_idx];
      bus.alu_src_b = req_b[grant_idx];
      bus.alu_op    = req_op[grant_idx];
    end
    result_in = op_ok ? bus.alu_result : '0;
  end

  always_comb begin
    rr_ptr_d = grant_vld ? ~grant_idx : rr_ptr_q;
    for (int i = 0; i < 2; i++) begin
      resp_valid_d[i]  = resp_valid_q[i];
      resp_err_d[i]    = resp_err_q[i];
      resp_result_d[i] = resp_result_q[i];
      if (accept[i]) begin
        resp_valid_d[i]  = 1'b1;
        resp_err_d[i]    = ~op_ok;
        resp_result_d[i] = result_in;
      end else if (bus.resp_ready[i]) begin
        resp_valid_d[i]  = 1'b0;
        resp_err_d[i]    = 1'b0;
      end
    end
  end

  // NOTE: state updates use <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= 1'b0;
      resp_valid_q  <= '0;
      resp_err_q    <= '0;
      // NOTE: the result buffers are reset too, so outputs read 0 straight out of reset.
      resp_result_q <= '{default: '0};
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_result_q <= resp_result_d;
    end
  end

  assign bus.req_ready    = accept;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp0_result = resp_result_q[0];
  assign bus.resp1_result = resp_result_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU; expected
// responses are queued at acceptance and compared when the buffers present them.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

`ifdef ALU_SHARE_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  localparam logic [OW-1:0] OP_AND = 4'b0000;
  localparam logic [OW-1:0] OP_OR  = 4'b0001;
  localparam logic [OW-1:0] OP_ADD = 4'b0010;
  localparam logic [OW-1:0] OP_SUB = 4'b0011;
  localparam logic [OW-1:0] OP_EQ  = 4'b1000;
  localparam logic [OW-1:0] OP_XOR = 4'b1001;
  localparam logic [OW-1:0] OP_SLT = 4'b1100;
  localparam logic [OW-1:0] OP_BAD = 4'b0111;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [OW-1:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_EQ:   return {{(DW-1){1'b0}}, a == b};
      OP_XOR:  return a ^ b;
      OP_SLT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  function automatic logic chk_legal(input logic [OW-1:0] op);
    return !OPCHECK || (op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_EQ, OP_XOR, OP_SLT});
  endfunction

  function automatic req_t mk(input int a, input int b, input logic [OW-1:0] op);
    req_t r;
    r.a  = DW'(a);
    r.b  = DW'(b);
    r.op = op;
    return r;
  endfunction

  assign bus.alu_result = alu_model(bus.alu_src_a, bus.alu_src_b, bus.alu_op);

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One request cycle: drive after the edge, check grant and ALU drive mid-cycle.
  task automatic step(input string tag, input logic [1:0] valid, input req_t r0, input req_t r1,
                      input logic [1:0] rready, input logic [1:0] exp_ready);
    req_t g;
    logic legal;
    exp_t e;
    @(posedge clk);
    #1;
    bus.req_valid  = valid;
    bus.req0_a     = r0.a;
    bus.req0_b     = r0.b;
    bus.req0_op    = r0.op;
    bus.req1_a     = r1.a;
    bus.req1_b     = r1.b;
    bus.req1_op    = r1.op;
    bus.resp_ready = rready;
    @(negedge clk);
    check({tag, "_ready"}, 72'(bus.req_ready), 72'(exp_ready));
    if (exp_ready != 2'b00) begin
      g     = exp_ready[1] ? r1 : r0;
      legal = chk_legal(g.op);
      check({tag, "_alu_op"}, 72'(bus.alu_op), 72'(legal ? g.op : 4'b0000));
      check({tag, "_alu_ab"}, 72'({bus.alu_src_a, bus.alu_src_b}),
            72'(legal ? {g.a, g.b} : 64'd0));
      e.result = legal ? alu_model(g.a, g.b, g.op) : '0;
      e.err    = !legal;
      if (exp_ready[1]) q1.push_back(e);
      else q0.push_back(e);
    end else begin
      check({tag, "_alu_idle"}, 72'({bus.alu_op, bus.alu_src_a, bus.alu_src_b}), 72'(0));
    end
  endtask

  // Response monitor: every presented response must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid[0]) begin
        if (q0.size() == 0) check("resp0_unexpected", 72'(bus.resp_valid[0]), 72'(0));
        else begin
          check("resp0_result", 72'(bus.resp0_result), 72'(q0[0].result));
          check("resp0_err", 72'(bus.resp_err[0]), 72'(q0[0].err));
          if (bus.resp_ready[0]) void'(q0.pop_front());
        end
      end
      if (bus.resp_valid[1]) begin
        if (q1.size() == 0) check("resp1_unexpected", 72'(bus.resp_valid[1]), 72'(0));
        else begin
          check("resp1_result", 72'(bus.resp1_result), 72'(q1[0].result));
          check("resp1_err", 72'(bus.resp_err[1]), 72'(q1[0].err));
          if (bus.resp_ready[1]) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    req_t none;
    none = mk(0, 0, OP_AND);
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b00;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;

    // Reset state, with both requesters already asking.
    #12;
    check("rst_req_ready", 72'(bus.req_ready), 72'(0));
    check("rst_resp_valid", 72'(bus.resp_valid), 72'(0));
    check("rst_results", 72'({bus.resp0_result, bus.resp1_result}), 72'(0));
    check("rst_err", 72'(bus.resp_err), 72'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 2'b00;

    // Contention straight after reset: r0 first, then alternate.
    step("cont1", 2'b11, mk(10, 4, OP_SUB), mk(32'hF0, 32'h0F, OP_XOR), 2'b11, 2'b01);
    step("cont2", 2'b11, mk(10, 4, OP_SUB), mk(32'hF0, 32'h0F, OP_XOR), 2'b11, 2'b10);
    check("cont2_rv", 72'(bus.resp_valid), 72'(2'b01));
    step("cont3", 2'b11, mk(10, 4, OP_SUB), mk(32'hF0, 32'h0F, OP_XOR), 2'b11, 2'b01);
    check("cont3_rv", 72'(bus.resp_valid), 72'(2'b10));
    step("cont4", 2'b11, mk(10, 4, OP_SUB), mk(32'hF0, 32'h0F, OP_XOR), 2'b11, 2'b10);
    step("idle1", 2'b00, none, none, 2'b11, 2'b00);

    // Single requester, one-cycle latency.
    step("add", 2'b01, mk(5, 3, OP_ADD), none, 2'b11, 2'b01);
    step("add_idle", 2'b00, none, none, 2'b11, 2'b00);
    check("add_rv", 72'(bus.resp_valid), 72'(2'b01));

    // Backpressure on r1 while r0 keeps being served.
    step("bp1", 2'b10, none, mk(3, 9, OP_SLT), 2'b01, 2'b10);
    step("bp2", 2'b11, mk(7, 1, OP_OR), mk(20, 5, OP_SUB), 2'b01, 2'b01);
    check("bp2_rv", 72'(bus.resp_valid), 72'(2'b10));
    step("bp3", 2'b11, mk(6, 6, OP_EQ), mk(20, 5, OP_SUB), 2'b01, 2'b01);
    check("bp3_rv", 72'(bus.resp_valid), 72'(2'b11));
    step("bp4", 2'b11, mk(8, 8, OP_AND), mk(20, 5, OP_SUB), 2'b11, 2'b10);
    step("bp5", 2'b01, mk(8, 8, OP_AND), none, 2'b11, 2'b01);
    step("bp_idle", 2'b00, none, none, 2'b11, 2'b00);

    // Drain and refill of the r0 buffer on the same edge.
    step("dr1", 2'b01, mk(1, 1, OP_ADD), none, 2'b11, 2'b01);
    step("dr2", 2'b01, mk(2, 7, OP_SLT), none, 2'b11, 2'b01);
    check("dr2_rv", 72'(bus.resp_valid), 72'(2'b01));
    step("dr3", 2'b00, none, none, 2'b11, 2'b00);
    check("dr3_rv", 72'(bus.resp_valid), 72'(2'b01));

    // Illegal opcode from r1.
    step("ill1", 2'b10, none, mk(12, 34, OP_BAD), 2'b11, 2'b10);
    step("ill2", 2'b00, none, none, 2'b11, 2'b00);
    check("ill_err", 72'(bus.resp_err), 72'(OPCHECK ? 2'b10 : 2'b00));

    // Both buffers pending, then asynchronous reset mid-cycle.
    step("rs1", 2'b11, mk(100, 1, OP_SUB), mk(5, 5, OP_EQ), 2'b00, 2'b01);
    step("rs2", 2'b11, mk(100, 1, OP_SUB), mk(5, 5, OP_EQ), 2'b00, 2'b10);
    step("rs3", 2'b11, mk(100, 1, OP_SUB), mk(5, 5, OP_EQ), 2'b00, 2'b00);
    check("rs3_rv", 72'(bus.resp_valid), 72'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rv", 72'(bus.resp_valid), 72'(0));
    check("mid_rst_results", 72'({bus.resp0_result, bus.resp1_result}), 72'(0));
    check("mid_rst_ready", 72'(bus.req_ready), 72'(0));
    check("mid_rst_err", 72'(bus.resp_err), 72'(0));
    q0.delete();
    q1.delete();
    bus.req_valid = 2'b00;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Priority pointer back at r0 after reset.
    step("post1", 2'b11, mk(9, 4, OP_SUB), mk(1, 2, OP_OR), 2'b11, 2'b01);
    step("post2", 2'b11, mk(9, 4, OP_SUB), mk(1, 2, OP_OR), 2'b11, 2'b10);
    step("post_idle1", 2'b00, none, none, 2'b11, 2'b00);
    step("post_idle2", 2'b00, none, none, 2'b11, 2'b00);
    check("sb_empty", 72'(q0.size() + q1.size()), 72'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
